// File: rtl/uart_pkg.sv
// ----------------------------------------------------------------------------
// uart_pkg
// Shared constants and types for the UART baud-rate generation path.
//
// Contents:
//   UART_DIV_W   default width of the integer divisor
//   UART_FRAC_W  default width of the fractional divisor
//   UART_OVS     default number of oversample ticks per bit
//   div_cfg_t    a divisor setting, integer and fractional parts together
// ----------------------------------------------------------------------------
package uart_pkg;

   localparam int UART_DIV_W  = 16;
   localparam int UART_FRAC_W = 4;
   localparam int UART_OVS    = 16;

   // One complete divisor setting. The field names avoid the keyword 'int'.
   typedef struct packed {
      logic [UART_DIV_W-1:0]  int_val;
      logic [UART_FRAC_W-1:0] frac_val;
   } div_cfg_t;

endpackage

// File: rtl/baud_frac_acc.sv
// ----------------------------------------------------------------------------
// baud_frac_acc
// Fractional phase accumulator for the baud generator. Each period boundary
// adds the fractional divisor into acc. The carry out becomes the
// period-extension bit, so the next s_tick period is one cycle longer.
//
// Ports:
//   clk    in   clock
//   rst    in   asynchronous reset, active-low
//   clear  in   synchronous clear of acc and carry (phase restart)
//   step   in   one-cycle strobe at each period boundary
//   frac   in   FRAC_W fractional divisor added on each step
//   carry  out  1 while the current period must be extended by one cycle
// ----------------------------------------------------------------------------
module baud_frac_acc
   import uart_pkg::*;
#(
   parameter int FRAC_W = UART_FRAC_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clear,
   input  logic              step,
   input  logic [FRAC_W-1:0] frac,
   output logic              carry
);

   logic [FRAC_W-1:0] acc;

   // The carry is fully replaced at every step. A long period therefore
   // lasts exactly one period, and the next step re-evaluates it.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         acc   <= '0;
         carry <= 1'b0;
      end else if (clear) begin
         acc   <= '0;
         carry <= 1'b0;
      end else if (step) begin
         {carry, acc} <= {1'b0, acc} + {1'b0, frac};
      end
   end

endmodule

// File: rtl/baud_tick_gen.sv
// ----------------------------------------------------------------------------
// baud_tick_gen
// Fractional baud-rate generator for the UART TX and RX paths. It emits a
// one-cycle oversample tick (s_tick) with an average period of
// div_int + div_frac/2^FRAC_W clock cycles. It also emits a bit tick on
// every OVS-th s_tick and a mid-bit tick on s_tick number OVS/2 of each bit.
//
// Ports:
//   clk       in   clock
//   rst       in   asynchronous reset, active-low
//   enable    in   counters advance while high and hold while low
//   restart   in   synchronous phase realign; overrides enable
//   div_int   in   DIV_W integer part of the s_tick period
//   div_frac  in   FRAC_W fractional part of the s_tick period
//   s_tick    out  oversample tick, one-cycle pulse
//   bit_tick  out  coincides with every OVS-th s_tick
//   mid_tick  out  coincides with s_tick number OVS/2 of each bit
//   cfg_err   out  high while the active integer divisor is below 2
// ----------------------------------------------------------------------------
module baud_tick_gen
   import uart_pkg::*;
#(
   parameter int DIV_W  = UART_DIV_W,
   parameter int FRAC_W = UART_FRAC_W,
   parameter int OVS    = UART_OVS
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              enable,
   input  logic              restart,
   input  logic [DIV_W-1:0]  div_int,
   input  logic [FRAC_W-1:0] div_frac,
   output logic              s_tick,
   output logic              bit_tick,
   output logic              mid_tick,
   output logic              cfg_err
);

   localparam int CNT_W = DIV_W + 1;
   localparam int OVS_W = (OVS > 1) ? $clog2(OVS) : 1;

   localparam logic [DIV_W-1:0] DIV_MIN  = DIV_W'(2);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [OVS_W-1:0] OVS_ONE  = OVS_W'(1);
   localparam logic [OVS_W-1:0] OVS_LAST = OVS_W'(OVS - 1);
   localparam logic [OVS_W-1:0] OVS_MID  = OVS_W'(OVS / 2 - 1);

   logic [CNT_W-1:0]  cnt;
   logic [OVS_W-1:0]  ovs_cnt;
   logic [DIV_W-1:0]  act_int;
   logic [FRAC_W-1:0] act_frac;
   logic              load_pending;
   logic              carry;

   logic [DIV_W-1:0]  eff_int;
   logic [CNT_W-1:0]  period;
   logic              at_end;
   logic              run;
   logic              fire;
   logic              reload;

   // The active divisor is clamped to 2, so a bad setting still produces
   // ticks (never back-to-back) instead of locking up. The counter is one
   // bit wider than the divisor so that max divisor plus carry still fits.
   // Reload happens on restart and at each period boundary. It also happens
   // on the first enabled edge after reset, so the first period after reset
   // uses the programmed divisor and not the cleared registers.
   always_comb begin
      eff_int = (act_int < DIV_MIN) ? DIV_MIN : act_int;
      period  = {1'b0, eff_int} + {{DIV_W{1'b0}}, carry};
      at_end  = (cnt == (period - CNT_ONE));
      run     = enable & ~restart;
      fire    = run & at_end;
      reload  = restart | fire | (run & load_pending);
   end

   baud_frac_acc #(
      .FRAC_W (FRAC_W)
   ) u_frac_acc (
      .clk    (clk),
      .rst    (rst),
      .clear  (restart),
      .step   (fire),
      .frac   (act_frac),
      .carry  (carry)
   );

   // Cycle counter and oversample counter. Restart wins over everything.
   // With enable low, both hold, so a resumed period continues its phase.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt          <= '0;
         ovs_cnt      <= '0;
         load_pending <= 1'b1;
      end else if (restart) begin
         cnt          <= '0;
         ovs_cnt      <= '0;
         load_pending <= 1'b0;
      end else if (enable) begin
         load_pending <= 1'b0;
         if (at_end) begin
            cnt     <= '0;
            ovs_cnt <= (ovs_cnt == OVS_LAST) ? '0 : (ovs_cnt + OVS_ONE);
         end else begin
            cnt <= cnt + CNT_ONE;
         end
      end
   end

   // Active divisor registers. A write to div_int/div_frac is only sampled
   // at a boundary, so the period in progress is never stretched or cut.
   // cfg_err follows the value being loaded, so it tracks the active setting.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         act_int  <= '0;
         act_frac <= '0;
         cfg_err  <= 1'b0;
      end else if (reload) begin
         act_int  <= div_int;
         act_frac <= div_frac;
         cfg_err  <= (div_int < DIV_MIN);
      end
   end

   // Registered tick outputs. bit_tick and mid_tick decode the ovs_cnt value
   // from before the advance, so they coincide with the s_tick that ends the
   // bit or the half-bit. OVS >= 4 keeps the two decodes distinct.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         s_tick   <= 1'b0;
         bit_tick <= 1'b0;
         mid_tick <= 1'b0;
      end else begin
         s_tick   <= fire;
         bit_tick <= fire & (ovs_cnt == OVS_LAST);
         mid_tick <= fire & (ovs_cnt == OVS_MID);
      end
   end

endmodule

// File: doc/baud_tick_gen.md
# baud_tick_gen

Parametrised fractional baud-rate generator for the UART. It produces a one-cycle oversample tick at an average period of div_int + div_frac/2^FRAC_W clock cycles, plus bit-rate and mid-bit ticks derived from it. The divisor is runtime-programmable, and a synchronous restart realigns phase to an RX start-bit edge. It feeds both the UART transmitter and receiver.

## Interface
- DIV_W, 16: width of integer divisor.
- FRAC_W, 4: width of fractional divisor; fractional resolution is 1/2^FRAC_W.
- OVS, 16: s_ticks per bit; even, ≥ 4.
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-low.
- enable  in  1  run when high; counters freeze when low.
- restart  in  1  synchronous phase realign; priority over enable.
- div_int  in  DIV_W  integer part of the s_tick period in clk cycles.
- div_frac  in  FRAC_W  fractional part of the s_tick period.
- s_tick  out  1  oversample tick, one-cycle pulse.
- bit_tick  out  1  pulse coincident with every OVS-th s_tick.
- mid_tick  out  1  pulse coincident with s_tick number OVS/2 of each bit.
- cfg_err  out  1  high while the active div_int < 2.

## Operation
- Internal state:
  - cnt (DIV_W+1 bits), cycle counter.
  - acc (FRAC_W bits), fractional accumulator.
  - carry (1 bit).
  - ovs_cnt (clog2(OVS) bits).
  - Active divisor registers act_int and act_frac.
- Period: period = max(act_int, 2) + carry.
- RUN (enable=1, restart=0), each clk:
  - If cnt == period-1: cnt←0, s_tick←1, {carry, acc}←acc + act_frac, and act_int/act_frac reload from the inputs.
  - Otherwise: cnt←cnt+1, s_tick←0.
- Divisor changes take effect only at a period boundary. A period already in progress is never stretched or truncated by a divisor write.
- ovs_cnt advances on each s_tick, wrapping OVS-1→0.
  - bit_tick←1 on the same edge as s_tick when ovs_cnt == OVS-1.
  - mid_tick←1 on the same edge as s_tick when ovs_cnt == OVS/2-1.
- HOLD (enable=0, restart=0): all counters, acc and carry hold their values. s_tick, bit_tick and mid_tick are 0. Resuming continues the same phase.
- restart=1: cnt, acc, carry and ovs_cnt clear to 0, act_int/act_frac reload from the inputs, and all tick outputs are 0 that cycle. This applies regardless of enable.
- cfg_err is registered and equals (act_int < 2). The generator runs with the clamped value 2 while cfg_err is high; no lockup.
- Average s_tick period is act_int + act_frac/2^FRAC_W cycles. Individual periods are act_int or act_int+1, with the longer periods spread by the accumulator carry.

## Timing
- Reset values: cnt, acc, carry and ovs_cnt are 0. act_int/act_frac are 0. s_tick, bit_tick, mid_tick and cfg_err are 0.
- The first s_tick after reset release uses the divisor loaded on the first enabled edge.
- After restart (or reset), with enable held high, the first s_tick is high in the cycle following act_int rising edges. All outputs are registered, with no combinational input-to-output path.
- Ticks are exactly one cycle wide. Back-to-back s_ticks never occur, because the minimum period is 2.
- bit_tick and mid_tick are never high without s_tick, and never both high in the same cycle.
- Simultaneous restart and tick condition: restart wins, and no tick is emitted.
- enable falling on a tick edge: the tick already registered is still output for its one cycle, then outputs go 0.
- Asynchronous reset mid-period: all state clears immediately, and no tick is emitted on release.

## Structure
- Package uart_pkg holds:
  - Default constants: UART_DIV_W=16, UART_FRAC_W=4, UART_OVS=16.
  - Typedef div_cfg_t, a struct of int and frac fields.
- One sub-module, baud_frac_acc, holds acc/carry and produces the period-extension bit.
- Top-level holds cnt, ovs_cnt, the active divisor registers and the output registers.

## Test plan
- 50 MHz clock, 115200 baud, 16x oversampling: div_int=27, div_frac=2, enable=1 → s_tick periods are 27 cycles, with 28-cycle periods taking 2 of every 16. Each bit_tick is exactly 434 cycles apart. mid_tick lands on the 8th s_tick of each bit.
- div_int=4, div_frac=0 → s_tick every 4 cycles. First s_tick 4 edges after restart. bit_tick every 64 cycles.
- Write div_int 10→5 mid-period → current period completes at 10 cycles, and the next is 5.
- Drop enable for 7 cycles mid-period → tick outputs stay 0, and the next s_tick is delayed by exactly 7 cycles.
- Pulse restart on the cycle a tick is due → no tick that cycle, ovs_cnt cleared, next bit_tick 16 × div_int cycles later.
- div_int=1 → cfg_err=1, s_tick every 2 cycles. Then div_int=3 → cfg_err clears after the next boundary.
- Assert rst mid-operation → every output reads 0 immediately.
